spi_peripheral: RTL and testbench

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

---
 rtl/spi_peripheral.sv | 169 ++++++++++++++++
 tb/tb_spi_peripheral.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI slave with synchronized pins, LSB-first shifting and a one-deep transmit holding register
module spi_peripheral #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] FILL  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             sclk,
    input  logic             ss_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             tx_underrun,
    output logic             frame_abort
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [2:0]       sclk_q, ss_q;
    logic [1:0]       mosi_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
    logic             hold_full_q, hold_full_d, first_q, first_d;
    logic             cpol_q, cpol_d, cpha_q, cpha_d, uf_pend_q, uf_pend_d;
    logic             rx_valid_q, rx_valid_d, tx_underrun_q, tx_underrun_d;
    logic             frame_abort_q, frame_abort_d;
    logic             ss_fall, ss_rise, lead, trail, samp, shft;

    assign ss_fall = ~ss_q[1] & ss_q[2];
    assign ss_rise = ss_q[1] & ~ss_q[2];
    assign lead    = cpol_q ? (~sclk_q[1] & sclk_q[2]) : (sclk_q[1] & ~sclk_q[2]);
    assign trail   = cpol_q ? (sclk_q[1] & ~sclk_q[2]) : (~sclk_q[1] & sclk_q[2]);
    assign samp    = cpha_q ? trail : lead;
    assign shft    = cpha_q ? lead : trail;

    assign miso_oe     = state_q != IDLE;
    assign busy        = miso_oe;
    assign miso        = miso_oe & tx_sh_q[0];
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_abort = frame_abort_q;

    // Two-flop synchronizers with a third stage kept for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            ss_q   <= '1;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            ss_q   <= {ss_q[1:0], ss_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    // Next state: ss_n rise wins over any same-cycle sclk edge; the first shift edge of a slot
    // is skipped because LOAD already put bit 0 on miso; underrun is reported once the slot
    // actually starts so the trailing LOAD at the end of a frame stays silent
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tx_sh_d       = tx_sh_q;
        rx_sh_d       = rx_sh_q;
        rx_data_d     = rx_data_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        first_d       = first_q;
        cpol_d        = cpol_q;
        cpha_d        = cpha_q;
        uf_pend_d     = uf_pend_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        frame_abort_d = 1'b0;
        if (ss_rise) begin
            state_d       = IDLE;
            cnt_d         = '0;
            rx_sh_d       = '0;
            uf_pend_d     = 1'b0;
            first_d       = 1'b1;
            frame_abort_d = state_q != IDLE && cnt_q != '0;
        end else begin
            case (state_q)
                IDLE: begin
                    first_d = 1'b1;
                    state_d = ss_fall ? LOAD : IDLE;
                end
                LOAD: begin
                    if (first_q) begin
                        cpol_d  = cpol;
                        cpha_d  = cpha;
                        first_d = 1'b0;
                    end
                    tx_sh_d   = hold_full_q ? hold_q : FILL;
                    uf_pend_d = ~hold_full_q;
                    state_d   = SHIFT;
                end
                default: begin
                    if (samp) begin
                        rx_sh_d       = {mosi_q[1], rx_sh_q[WIDTH-1:1]};
                        tx_underrun_d = uf_pend_q;
                        uf_pend_d     = 1'b0;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            cnt_d      = '0;
                            rx_data_d  = rx_sh_d;
                            rx_valid_d = 1'b1;
                            state_d    = LOAD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else if (shft && cnt_q != '0) begin
                        tx_sh_d = tx_sh_q >> 1;
                    end
                end
            endcase
        end
        if (state_q == LOAD) hold_full_d = 1'b0;
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            tx_sh_q       <= '0;
            rx_sh_q       <= '0;
            rx_data_q     <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            first_q       <= 1'b1;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            uf_pend_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tx_sh_q       <= tx_sh_d;
            rx_sh_q       <= rx_sh_d;
            rx_data_q     <= rx_data_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            first_q       <= first_d;
            cpol_q        <= cpol_d;
            cpha_q        <= cpha_d;
            uf_pend_q     <= uf_pend_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            frame_abort_q <= frame_abort_d;
        end
    end
endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: controller-side bench comparing spi_peripheral against a byte-level model
module tb_spi_peripheral;
    localparam int H = 6;
    localparam logic [7:0] FILL = 8'h00;

    logic       clk, rst_n, cpol, cpha, sclk, ss_n, mosi;
    logic       miso, miso_oe, tx_valid, tx_ready, rx_valid, busy, tx_underrun, frame_abort;
    logic [7:0] tx_data, rx_data;

    int         n_chk, n_err, uf_tot, ab_tot;
    logic [7:0] rx_q[$];
    time        rx_t[$];
    logic       m_full;
    logic [7:0] m_hold;

    spi_peripheral dut (
        .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss_n(ss_n),
        .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .tx_underrun(tx_underrun), .frame_abort(frame_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every received byte with its time, and count the one-cycle pulses
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_q.push_back(rx_data);
            rx_t.push_back($time);
        end
        if (tx_underrun) uf_tot++;
        if (frame_abort) ab_tot++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] v);
        for (int c = 0; c < 20 && !tx_ready; c++) wait_clk(1);
        chk("tx_ready", tx_ready, 1);
        tx_data  = v;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    task automatic preload(input logic [7:0] v);
        load_tx(v);
        m_full = 1'b1;
        m_hold = v;
    endtask

    task automatic run_frame(input logic pol, input logic pha, input int nb, input int pbits,
                             input logic rst_mid, input logic mid_ld, input logic [7:0] mid_v,
                             input logic [7:0] b0);
        logic [7:0] mo[4];
        logic [7:0] exp_out[$];
        logic [7:0] got, out;
        time        et[$];
        int         uf0, ab0, rx0, exp_uf, total;
        mo[0] = b0;
        for (int k = 1; k < 4; k++) mo[k] = 8'($urandom);
        exp_uf = 0;
        got    = '0;
        for (int s = 0; s <= nb; s++) begin
            if (s == 1 && mid_ld) begin
                m_full = 1'b1;
                m_hold = mid_v;
            end
            out = m_full ? m_hold : FILL;
            if (!m_full && (s < nb || pbits > 0)) exp_uf++;
            m_full = 1'b0;
            exp_out.push_back(out);
        end
        if (nb == 0 && mid_ld) begin
            m_full = 1'b1;
            m_hold = mid_v;
        end
        uf0  = uf_tot;
        ab0  = ab_tot;
        rx0  = rx_q.size();
        cpol = pol;
        cpha = pha;
        sclk = pol;
        mosi = 1'b0;
        wait_clk(4);
        ss_n = 1'b0;
        wait_clk(H);
        chk("miso_oe_on", miso_oe, 1);
        chk("busy_on", busy, 1);
        if (mid_ld) load_tx(mid_v);
        total = nb * 8 + pbits;
        for (int k = 0; k < total; k++) begin
            int i;
            i = k % 8;
            if (!pha) begin
                mosi = mo[k/8][i];
                wait_clk(H);
                got[i] = miso;
                sclk   = ~pol;
                if (i == 7) et.push_back($time);
                wait_clk(H);
                sclk = pol;
            end else begin
                sclk = ~pol;
                mosi = mo[k/8][i];
                wait_clk(H);
                got[i] = miso;
                sclk   = pol;
                if (i == 7) et.push_back($time);
                wait_clk(H);
            end
            if (i == 7) chk($sformatf("miso_byte%0d", k / 8), got, exp_out[k/8]);
        end
        if (!pha) wait_clk(H);
        if (rst_mid) begin
            rst_n = 1'b0;
            #1;
            chk("rst_miso", miso, 0);
            chk("rst_miso_oe", miso_oe, 0);
            chk("rst_busy", busy, 0);
            chk("rst_tx_ready", tx_ready, 1);
            chk("rst_rx_data", rx_data, 0);
            chk("rst_rx_valid", rx_valid, 0);
            chk("rst_underrun", tx_underrun, 0);
            chk("rst_abort", frame_abort, 0);
            ss_n   = 1'b1;
            sclk   = pol;
            mosi   = 1'b0;
            m_full = 1'b0;
            wait_clk(2);
            rst_n = 1'b1;
        end else begin
            ss_n = 1'b1;
            wait_clk(4);
            chk("busy_end", busy, 0);
        end
        wait_clk(6);
        chk("rx_count", rx_q.size() - rx0, nb);
        for (int j = 0; j < nb && rx0 + j < rx_q.size() && j < et.size(); j++) begin
            chk($sformatf("rx_data%0d", j), rx_q[rx0+j], mo[j]);
            chk($sformatf("rx_lat%0d", j), 32'(rx_t[rx0+j] - et[j]), 30);
        end
        chk("underrun_count", uf_tot - uf0, exp_uf);
        chk("abort_count", ab_tot - ab0, (pbits > 0 && !rst_mid) ? 1 : 0);
    endtask

    initial begin
        int nb, pb;
        logic ml;
        n_chk = 0; n_err = 0; uf_tot = 0; ab_tot = 0;
        rst_n = 1'b0; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
        tx_data = '0; tx_valid = 1'b0; m_full = 1'b0; m_hold = '0;
        #1;
        chk("init_miso", miso, 0);
        chk("init_miso_oe", miso_oe, 0);
        chk("init_busy", busy, 0);
        chk("init_tx_ready", tx_ready, 1);
        chk("init_rx_data", rx_data, 0);
        chk("init_rx_valid", rx_valid, 0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);
        for (int m = 0; m < 4; m++) begin
            logic [1:0] md;
            md = 2'(m);
            preload(8'hA5);
            run_frame(md[1], md[0], 1, 0, 1'b0, 1'b0, 8'h00, 8'h3C);
        end
        preload(8'hA5);
        run_frame(1'b0, 1'b0, 2, 0, 1'b0, 1'b1, 8'h5A, 8'h3C);
        preload(8'hA5);
        run_frame(1'b0, 1'b0, 2, 0, 1'b0, 1'b0, 8'h00, 8'h3C);
        preload(8'hA5);
        run_frame(1'b0, 1'b0, 0, 5, 1'b0, 1'b0, 8'h00, 8'h3C);
        preload(8'hC3);
        run_frame(1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 8'h00, 8'h3C);
        preload(8'hA5);
        run_frame(1'b0, 1'b0, 0, 3, 1'b1, 1'b0, 8'h00, 8'h3C);
        preload(8'h96);
        run_frame(1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 8'h00, 8'h3C);
        for (int f = 0; f < 30; f++) begin
            nb = $urandom_range(0, 3);
            pb = (nb == 0 || $urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            ml = (nb >= 1) && ($urandom_range(0, 1) == 1);
            if (!m_full && $urandom_range(0, 3) != 0) preload(8'($urandom));
            run_frame(1'($urandom), 1'($urandom), nb, pb, 1'b0, ml, 8'($urandom), 8'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
